// File: rtl/jzjpcc_mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// jzjpcc_mem_access_unit: load/store unit with word-aligned bus beats,
// byte masks and load extension; word-crossing accesses split in two.
// Revision: 1.0
// ==========================================================================
module jzjpcc_mem_access_unit #(
  parameter int ADDR_WIDTH       = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic                  bus_write,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_byteMask,
  output logic [31:0]           bus_wdata,
  input  logic [31:0]           bus_rdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_fault
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    write_q, write_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    fault_q, fault_d;
  logic [31:0]             rdata0_q, rdata0_d;
  logic [31:0]             rdata1_q, rdata1_d;

  function automatic logic [7:0] f_mask64(input logic [1:0] sz, input logic [1:0] off);
    logic [7:0] base;
    case (sz)
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

  function automatic logic f_split(input logic [1:0] sz, input logic [1:0] off);
    return (f_mask64(sz, off) & 8'hF0) != 8'h00;
  endfunction

  function automatic logic f_illegal(input logic wr, input logic [2:0] f3);
    if (wr) return f3[2] || (f3[1:0] == 2'b11);
    return (f3[1:0] == 2'b11) || (f3 == 3'b110);
  endfunction

  logic                  req_fault;
  logic [7:0]            mask64;
  logic                  split;
  logic [5:0]            shamt;
  logic [63:0]           wdata64;
  logic [ADDR_WIDTH-1:0] beat0_addr;
  logic [ADDR_WIDTH-1:0] beat1_addr;
  logic [31:0]           rdata_sh;
  logic                  sext;
  logic [31:0]           load_ext;

  assign req_fault  = f_illegal(req_write, req_funct3) ||
                      (!ALLOW_MISALIGNED && f_split(req_funct3[1:0], req_addr[1:0]));
  assign mask64     = f_mask64(funct3_q[1:0], addr_q[1:0]);
  assign split      = |mask64[7:4];
  assign shamt      = {addr_q[1:0], 3'b000};
  assign wdata64    = {32'h0, wdata_q} << shamt;
  assign beat0_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign beat1_addr = beat0_addr + ADDR_WIDTH'(4);
  assign rdata_sh   = 32'({rdata1_q, rdata0_q} >> shamt);
  assign sext       = ~funct3_q[2];

  always_comb begin
    load_ext = 32'h0;
    case (funct3_q[1:0])
      2'b00:   load_ext = {{24{sext & rdata_sh[7]}}, rdata_sh[7:0]};
      2'b01:   load_ext = {{16{sext & rdata_sh[15]}}, rdata_sh[15:0]};
      default: load_ext = rdata_sh;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      fault_q  <= 1'b0;
      rdata0_q <= 32'h0;
      rdata1_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      fault_q  <= fault_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Bus and response fields are zero outside their owning states.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    fault_d      = fault_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    req_ready    = 1'b0;
    bus_valid    = 1'b0;
    bus_write    = 1'b0;
    bus_addr     = '0;
    bus_byteMask = 4'h0;
    bus_wdata    = 32'h0;
    resp_valid   = 1'b0;
    resp_rdata   = 32'h0;
    resp_fault   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          fault_d  = req_fault;
          rdata0_d = 32'h0;
          rdata1_d = 32'h0;
          state_d  = req_fault ? ST_RESP : ST_BEAT0;
        end
      end
      ST_BEAT0: begin
        bus_valid    = 1'b1;
        bus_write    = write_q;
        bus_addr     = beat0_addr;
        bus_byteMask = mask64[3:0];
        bus_wdata    = wdata64[31:0];
        if (bus_ready) begin
          rdata0_d = bus_rdata;
          state_d  = split ? ST_BEAT1 : ST_RESP;
        end
      end
      ST_BEAT1: begin
        bus_valid    = 1'b1;
        bus_write    = write_q;
        bus_addr     = beat1_addr;
        bus_byteMask = mask64[7:4];
        bus_wdata    = wdata64[63:32];
        if (bus_ready) begin
          rdata1_d = bus_rdata;
          state_d  = ST_RESP;
        end
      end
      default: begin
        resp_valid = 1'b1;
        resp_fault = fault_q;
        resp_rdata = (write_q || fault_q) ? 32'h0 : load_ext;
        if (resp_ready) state_d = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_jzjpcc_mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for jzjpcc_mem_access_unit: directed and random transactions checked
// against a byte-level reference model; a second instance has misaligned support off.
module tb_jzjpcc_mem_access_unit;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        req_valid  = 1'b0;
  logic        req_write  = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr   = 32'h0;
  logic [31:0] req_wdata  = 32'h0;
  logic        bus_ready  = 1'b0;
  logic [31:0] bus_rdata  = 32'h0;
  logic        resp_ready = 1'b0;
  logic        sel_nm     = 1'b0;

  logic        a_req_ready, a_bus_valid, a_bus_write, a_resp_valid, a_resp_fault;
  logic [31:0] a_bus_addr, a_bus_wdata, a_resp_rdata;
  logic [3:0]  a_bus_mask;
  logic        n_req_ready, n_bus_valid, n_bus_write, n_resp_valid, n_resp_fault;
  logic [31:0] n_bus_addr, n_bus_wdata, n_resp_rdata;
  logic [3:0]  n_bus_mask;

  jzjpcc_mem_access_unit #(.ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid & ~sel_nm), .req_ready(a_req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .bus_valid(a_bus_valid), .bus_ready(bus_ready & ~sel_nm), .bus_write(a_bus_write),
    .bus_addr(a_bus_addr), .bus_byteMask(a_bus_mask), .bus_wdata(a_bus_wdata), .bus_rdata(bus_rdata),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready & ~sel_nm),
    .resp_rdata(a_resp_rdata), .resp_fault(a_resp_fault)
  );

  jzjpcc_mem_access_unit #(.ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b0)) dut_nm (
    .clock(clock), .reset(reset),
    .req_valid(req_valid & sel_nm), .req_ready(n_req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .bus_valid(n_bus_valid), .bus_ready(bus_ready & sel_nm), .bus_write(n_bus_write),
    .bus_addr(n_bus_addr), .bus_byteMask(n_bus_mask), .bus_wdata(n_bus_wdata), .bus_rdata(bus_rdata),
    .resp_valid(n_resp_valid), .resp_ready(resp_ready & sel_nm),
    .resp_rdata(n_resp_rdata), .resp_fault(n_resp_fault)
  );

  logic        req_ready, bus_valid, bus_write, resp_valid, resp_fault;
  logic [31:0] bus_addr, bus_wdata, resp_rdata;
  logic [3:0]  bus_byteMask;
  assign req_ready    = sel_nm ? n_req_ready  : a_req_ready;
  assign bus_valid    = sel_nm ? n_bus_valid  : a_bus_valid;
  assign bus_write    = sel_nm ? n_bus_write  : a_bus_write;
  assign bus_addr     = sel_nm ? n_bus_addr   : a_bus_addr;
  assign bus_byteMask = sel_nm ? n_bus_mask   : a_bus_mask;
  assign bus_wdata    = sel_nm ? n_bus_wdata  : a_bus_wdata;
  assign resp_valid   = sel_nm ? n_resp_valid : a_resp_valid;
  assign resp_rdata   = sel_nm ? n_resp_rdata : a_resp_rdata;
  assign resp_fault   = sel_nm ? n_resp_fault : a_resp_fault;

  logic [104:0] a_all, n_all;
  assign a_all = {a_req_ready, a_bus_valid, a_bus_write, a_bus_addr, a_bus_mask, a_bus_wdata,
                  a_resp_valid, a_resp_rdata, a_resp_fault};
  assign n_all = {n_req_ready, n_bus_valid, n_bus_write, n_bus_addr, n_bus_mask, n_bus_wdata,
                  n_resp_valid, n_resp_rdata, n_resp_fault};
  localparam logic [104:0] RST_VEC = {1'b1, 104'h0};

  int  checks = 0;
  int  errors = 0;
  time t_accept = 0;

  bit          e_fault;
  int          e_nb;
  logic [31:0] e_addr[2];
  logic [3:0]  e_mask[2];
  logic [31:0] e_wdata[2];
  logic [31:0] e_rdata;

  // Reference model: walks the accessed bytes one at a time.
  task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] rs2, input logic [31:0] rd0, input logic [31:0] rd1,
                       input bit allow);
    int size, o, lane;
    bit legal, crosses;
    logic [63:0] w64;
    logic [31:0] rd1_eff;
    logic [7:0]  b;
    longint v;
    case (f3[1:0])
      2'd0:    size = 1;
      2'd1:    size = 2;
      2'd2:    size = 4;
      default: size = 0;
    endcase
    legal   = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    o       = int'(addr[1:0]);
    crosses = (o + size) > 4;
    e_fault = !legal || (!allow && crosses);
    e_nb    = e_fault ? 0 : (crosses ? 2 : 1);
    e_addr[0] = addr & 32'hFFFF_FFFC;
    e_addr[1] = e_addr[0] + 32'd4;
    e_mask[0] = 4'h0;
    e_mask[1] = 4'h0;
    for (int i = 0; i < size; i++) e_mask[(o + i) / 4][(o + i) % 4] = 1'b1;
    w64 = {32'h0, rs2} << (8 * o);
    e_wdata[0] = w64[31:0];
    e_wdata[1] = w64[63:32];
    rd1_eff = crosses ? rd1 : 32'h0;
    v = 0;
    for (int i = 0; i < size; i++) begin
      lane = o + i;
      if (lane < 4) b = rd0[8*lane +: 8];
      else          b = rd1_eff[8*(lane-4) +: 8];
      v += longint'(b) << (8 * i);
    end
    if (!f3[2] && size > 0 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
      v -= longint'(1) << (8 * size);
    e_rdata = (wr || e_fault) ? 32'h0 : v[31:0];
  endtask

  // Called right after a falling edge; returns right after a falling edge.
  task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [31:0] rd0, input logic [31:0] rd1,
                         input bit nm, input int stall_pct, input int b1_stalls,
                         input bit early_rr, input string tag);
    int c = 0;
    int beat = 0;
    int stalls = 0;
    int forced = b1_stalls;
    int hold;
    bit got = 0;
    model(wr, f3, addr, rs2, rd0, rd1, !nm);
    sel_nm     = nm;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = rs2;
    req_valid  = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready_idle: got %b want 1", tag, req_ready);
    end
    @(posedge clock);
    t_accept = $time;
    #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    resp_ready = early_rr;
    while (!got && c < 60) begin
      @(negedge clock);
      c++;
      bus_ready = 1'b0;
      if (resp_valid) got = 1;
      else if (bus_valid) begin
        checks++;
        if (beat >= e_nb) begin
          errors++;
          $display("FAIL %s unexpected_beat: got bus_valid at cycle %0d want %0d beats", tag, c, e_nb);
        end else begin
          if ({bus_write, bus_addr, bus_byteMask, bus_wdata} !==
              {wr, e_addr[beat], e_mask[beat], e_wdata[beat]}) begin
            errors++;
            $display("FAIL %s beat%0d: got w=%b a=%h m=%b d=%h want w=%b a=%h m=%b d=%h", tag, beat,
                     bus_write, bus_addr, bus_byteMask, bus_wdata,
                     wr, e_addr[beat], e_mask[beat], e_wdata[beat]);
          end
          bus_rdata = (beat == 0) ? rd0 : rd1;
          if (beat == 1 && forced > 0) begin
            forced--;
            stalls++;
          end else if ($urandom_range(99) < stall_pct) begin
            stalls++;
          end else begin
            bus_ready = 1'b1;
            beat++;
          end
        end
      end
    end
    bus_ready = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no resp_valid after %0d cycles", tag, c);
      resp_ready = 1'b0;
      return;
    end
    if (c != 1 + e_nb + stalls || beat != e_nb) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles/%0d beats want %0d cycles/%0d beats",
               tag, c, beat, 1 + e_nb + stalls, e_nb);
    end
    checks++;
    if (resp_rdata !== e_rdata || resp_fault !== e_fault || bus_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s response: got rdata=%h fault=%b bv=%b rr=%b want rdata=%h fault=%b bv=0 rr=0",
               tag, resp_rdata, resp_fault, bus_valid, req_ready, e_rdata, e_fault);
    end
    if (!early_rr) begin
      hold = $urandom_range(0, 2);
      repeat (hold) begin
        @(negedge clock);
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== e_rdata || resp_fault !== e_fault) begin
          errors++;
          $display("FAIL %s resp_hold: got v=%b rdata=%h fault=%b want v=1 rdata=%h fault=%b",
                   tag, resp_valid, resp_rdata, resp_fault, e_rdata, e_fault);
        end
      end
      resp_ready = 1'b1;
    end
    @(negedge clock);
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after_handshake: got resp_valid=%b req_ready=%b want 0/1", tag, resp_valid, req_ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (a_all !== RST_VEC) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", a_all, RST_VEC);
    end
    checks++;
    if (n_all !== RST_VEC) begin
      errors++;
      $display("FAIL reset_state_nm: got %h want %h", n_all, RST_VEC);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_directed;
    run_txn(1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 32'h0, 1'b0, 0, 0, 1'b0, "SB_1003");
    run_txn(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_1234, 32'h5555_5555, 1'b0, 0, 0, 1'b0, "LH_2002");
    run_txn(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_1234, 32'h5555_5555, 1'b0, 0, 0, 1'b1, "LHU_2002");
    run_txn(1'b1, 3'b010, 32'h0000_3001, 32'h1122_3344, 32'h0, 32'h0, 1'b0, 0, 0, 1'b0, "SW_3001");
    run_txn(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 32'hBBAA_1234, 32'h9876_DDCC, 1'b0, 0, 2, 1'b0, "LW_wrap_stall");
    run_txn(1'b0, 3'b000, 32'h0000_0007, 32'h0, 32'h80FF_0000, 32'h0, 1'b0, 0, 0, 1'b0, "LB_neg");
    run_txn(1'b0, 3'b100, 32'h0000_0007, 32'h0, 32'h80FF_0000, 32'h0, 1'b0, 0, 0, 1'b0, "LBU");
  endtask

  task automatic test_fault;
    run_txn(1'b0, 3'b011, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 0, 1'b0, "LD_f3_011");
    run_txn(1'b1, 3'b101, 32'h0000_4004, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 0, 0, 1'b1, "ST_f3_101");
    run_txn(1'b0, 3'b110, 32'h0000_4008, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 0, 1'b0, "LD_f3_110");
  endtask

  task automatic test_no_misaligned;
    run_txn(1'b1, 3'b001, 32'h0000_5003, 32'hCAFE_F00D, 32'h0, 32'h0, 1'b1, 0, 0, 1'b0, "NM_SH_o3");
    run_txn(1'b0, 3'b010, 32'h0000_5001, 32'h0, 32'h1111_2222, 32'h0, 1'b1, 0, 0, 1'b0, "NM_LW_o1");
    run_txn(1'b1, 3'b010, 32'h0000_5004, 32'hCAFE_F00D, 32'h0, 32'h0, 1'b1, 0, 0, 1'b0, "NM_SW_aligned");
    run_txn(1'b0, 3'b001, 32'h0000_5002, 32'h0, 32'h7F00_0000, 32'h0, 1'b1, 0, 0, 1'b0, "NM_LH_o2");
  endtask

  task automatic test_back_to_back;
    time prev;
    for (int i = 0; i < 4; i++) begin
      prev = t_accept;
      run_txn(1'b0, 3'b010, 32'h0000_6000 + 32'(4 * i), 32'h0, $urandom, 32'h0, 1'b0, 0, 0, 1'b1, "B2B");
      if (i > 0) begin
        checks++;
        if (t_accept - prev != 30) begin
          errors++;
          $display("FAIL b2b_throughput: got %0t between accepts want 30", t_accept - prev);
        end
      end
    end
  endtask

  task automatic test_random;
    logic       wr;
    logic [2:0] f3;
    logic [31:0] addr;
    int k;
    for (int i = 0; i < 200; i++) begin
      wr = 1'($urandom_range(1));
      k  = $urandom_range(4);
      if ($urandom_range(9) == 0) f3 = 3'($urandom);
      else if (wr)                f3 = 3'($urandom_range(2));
      else                        f3 = (k < 3) ? 3'(k) : 3'(k + 1);
      addr = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(3)) : $urandom;
      run_txn(wr, f3, addr, $urandom, $urandom, $urandom, ($urandom_range(3) == 0),
              30, 0, 1'($urandom_range(1)), "RAND");
    end
  endtask

  task automatic test_reset_mid;
    sel_nm     = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_3002;
    req_valid  = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    bus_rdata = 32'h1234_5678;
    bus_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    bus_ready = 1'b0;
    checks++;
    if (a_bus_valid !== 1'b1 || a_bus_addr !== 32'h0000_3004) begin
      errors++;
      $display("FAIL reset_mid_beat1: got bv=%b addr=%h want bv=1 addr=00003004", a_bus_valid, a_bus_addr);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (a_all !== RST_VEC) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h want %h", a_all, RST_VEC);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clock);
      checks++;
      if (a_resp_valid !== 1'b0 || a_bus_valid !== 1'b0 || a_req_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_after: got resp_valid=%b bus_valid=%b req_ready=%b want 0/0/1",
                 a_resp_valid, a_bus_valid, a_req_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_fault();
    test_no_misaligned();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jzjpcc_mem_access_unit.md
# jzjpcc_mem_access_unit

Sequential load/store access unit between the execute stage and the data-memory bus. It takes one memory request (address, funct3, store data), generates word-aligned bus beats with byte masks and shifted write data, and returns sign/zero-extended load data. It generalises the combinational byte-mask/store-data generation with a valid/ready handshake, load-data assembly, and optional splitting of misaligned accesses into two bus beats.

## Interface

Parameters:
- ADDR_WIDTH, 32, byte-address width; must be ≥ 3.
- ALLOW_MISALIGNED, 1, 1 = split word-crossing accesses into two beats; 0 = report a fault with no bus traffic.

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; the polarity and synchronicity are fixed.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I load/store funct3.
- req_addr  in  ADDR_WIDTH  byte address (alu result).
- req_wdata  in  32  rs2 value.
- bus_valid  out  1  beat presented.
- bus_ready  in  1  memory accepts beat; for reads, bus_rdata is valid in the same cycle.
- bus_write  out  1  beat is a write.
- bus_addr  out  ADDR_WIDTH  word-aligned; bits [1:0] = 0.
- bus_byteMask  out  4  active bytes of beat.
- bus_wdata  out  32  lane-aligned write data.
- bus_rdata  in  32  read data.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  illegal funct3, or misaligned with ALLOW_MISALIGNED=0.

## Operation

- Size from funct3[1:0]: 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes.
- funct3[2] = 1 means zero-extend; it is valid only for loads with size 1 or 2.
- Legal funct3 values: stores 000/001/010; loads 000/001/010/100/101. All other codes set fault.
- Offset o = addr[1:0]. Mask64 = ((1<<size)−1) << o. Beat0 mask = Mask64[3:0]; beat1 mask = Mask64[7:4].
- A request is split if beat1 mask ≠ 0. Examples: SH at o = 3, SW at o ≥ 1.
- Write data: W64 = {32'b0, rs2} << (8·o). Beat0 carries W64[31:0], beat1 carries W64[63:32]. Unmasked lanes are don't-care but driven from W64.
- Beat0 address = {addr[ADDR_WIDTH−1:2], 2'b00}. Beat1 address = beat0 address + 4, modulo 2^ADDR_WIDTH (wraps to 0).
- Load data: R64 = {rdata_beat1, rdata_beat0} >> (8·o). Take the low `size` bytes and sign- or zero-extend. For an unsplit load, rdata_beat1 = 0.

FSM states:
- IDLE: req_ready = 1. On req_valid, latch the request.
  - Fault → RESP.
  - Otherwise → BEAT0.
- BEAT0: bus_valid = 1 with beat0 fields.
  - On bus_ready, capture rdata.
  - If split → BEAT1, else → RESP.
- BEAT1: bus_valid = 1 with beat1 fields. On bus_ready, capture rdata → RESP.
- RESP: resp_valid = 1 and outputs stay stable. On resp_ready → IDLE.
- Bus fields stay stable while bus_valid = 1 and bus_ready = 0.
- No new request is accepted until the response is consumed; there is one request in flight.

## Timing

- Reset (asynchronous, while reset = 0):
  - State = IDLE.
  - req_ready = 1; bus_valid = 0; resp_valid = 0.
  - bus_write, bus_addr, bus_byteMask, bus_wdata, resp_rdata, resp_fault all = 0.
- Reset asserted mid-transaction aborts it immediately. No response is produced after release.
- Latency with bus_ready held high:
  - Aligned: accept at cycle N, beat at N+1, resp_valid at N+2.
  - Split: beats at N+1 and N+2, resp_valid at N+3.
  - Fault: resp_valid at N+1, with no bus_valid.
- Each bus_ready = 0 cycle adds one cycle of latency.
- resp_ready may be high before resp_valid; the handshake completes in the first cycle both are high.
- req_ready is combinational from state only (IDLE), not from req_valid.
- A new request can be accepted in the cycle after the resp handshake. Throughput is one aligned request per 3 cycles.

## Test plan

- SB, addr 0x1003, rs2 0xAABBCCDD → one beat: addr 0x1000, mask 1000, wdata[31:24] = 0xDD; resp_rdata = 0, fault = 0.
- LH, addr 0x2002, rdata 0x8001_xxxx → resp_rdata 0xFFFF8001. Same request as LHU → 0x00008001.
- SW, addr 0x3001, ALLOW_MISALIGNED = 1, rs2 0x11223344:
  - Beat0: addr 0x3000, mask 1110, wdata 0x223344xx.
  - Beat1: addr 0x3004, mask 0001, wdata 0xxxxxxx11.
- LW, addr 0xFFFFFFFE, rdata0 0xBBAA_xxxx, rdata1 0xxxxx_DDCC:
  - Beat1 addr = 0x00000000.
  - resp_rdata = 0xDDCCBBAA.
  - With bus_ready low for 2 cycles in BEAT1, latency is +2 and beat fields stay stable.
- Faults:
  - funct3 = 011 → resp_fault = 1 at N+1, no bus_valid.
  - SH at o = 3 with ALLOW_MISALIGNED = 0 → fault, no bus_valid.
- reset = 0 asserted during BEAT1 → all outputs return to reset values in the same cycle. After release, req_ready = 1 and no resp_valid appears.
